edge_event_arbiter: RTL
=======================

// Module: edge_event_arbiter
// PURPOSE
//   Multi-channel edge-event scheduler. Runs per-channel edge detection on CH_NUM level
//   inputs (keys, strobes) and queues each rising/falling edge as a pending event.
//   Pending events share one valid/ready output port through round-robin arbitration.
//   Sits between raw edge sources and a single event consumer (LED/UART/control FSM).
// PARAMETERS
//   CH_NUM   4   number of input channels (1..16)
//   SYNC_EN  1   1: two-flop synchronizer per channel (async inputs); 0: single input register
//   CH_W     derived = (CH_NUM>1) ? $clog2(CH_NUM) : 1; not overridable
// PORTS
//   clk        in   1        system clock; all logic on posedge
//   rst_n      in   1        synchronous reset, active low
//   a          in   CH_NUM   raw level inputs, one bit per channel
//   evt_valid  out  1        event offered on evt_ch/evt_pos
//   evt_ready  in   1        consumer accepts event when evt_valid=1
//   evt_ch     out  CH_W     channel index of offered event
//   evt_pos    out  1        1 = rising edge, 0 = falling edge
//   pend       out  CH_NUM   per-channel pending flag, including the one being offered
//   ovf        out  CH_NUM   sticky: edge dropped because channel already pending
//   ovf_clr    in   1        one-cycle pulse, clears all ovf bits
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): sync/prev regs=0, pend=0, ovf=0, evt_valid=0, evt_ch=0,
//     evt_pos=0, last_grant=CH_NUM-1 (ch0 has first priority), FSM=IDLE.
//   Inputs high at reset release produce one rising event per channel (prev resets to 0).
//   Edge detect per channel: s = synchronized level, p = s delayed 1 cycle.
//     rise = s & ~p; fall = ~s & p; both are single-cycle and combinational from regs.
//   Latency: first posedge sampling the new a level -> pend bit set at the posedge
//     3 cycles later (SYNC_EN=1) or 2 cycles later (SYNC_EN=0).
//   Pending: per channel, pend_vld and pend_pol.
//     Edge while !pend_vld -> set pend_vld, pend_pol = rise.
//     Edge while pend_vld (incl. while being offered) -> new edge dropped, ovf[i]=1,
//       stored event unchanged.
//     Same-cycle accept of channel i and new edge on i -> pend cleared, then re-set with
//       the new edge; no overflow.
//   FSM: IDLE, OFFER.
//     IDLE: if any pend_vld, choose first set channel scanning last_grant+1, +2, ...
//       (mod CH_NUM). Register evt_ch, evt_pos=pend_pol, evt_valid=1; go OFFER.
//       Otherwise stay in IDLE with evt_valid=0.
//     OFFER: evt_ch and evt_pos held stable while evt_ready=0 (no re-arbitration).
//       On evt_valid & evt_ready: clear pend_vld[evt_ch], last_grant=evt_ch,
//       evt_valid=0 next cycle, go IDLE.
//     Peak throughput: one event per 2 cycles.
//   ovf: sticky until ovf_clr. ovf_clr and a new overflow on the same channel in the same
//     cycle -> set wins.
//   Reset mid-operation: everything returns to reset values at that posedge. Pending and
//     offered events are discarded, with no handshake completed.
//   pend output = pend_vld registers directly; no combinational path from a to outputs.
// TESTING
//   1 rst_n=0 for 200ns with a=0 -> evt_valid=0, pend=0, ovf=0, evt_ch=0 throughout.
//   2 SYNC_EN=1, evt_ready=1, a[0] 0->1, held 100ns, then 1->0 -> exactly two
//     handshakes: (ch0,pos=1) then (ch0,pos=0); pend[0] set 3 cycles after sampling.
//   3 a 4'h0 -> 4'hF in one cycle, evt_ready=1 -> grants ch0,1,2,3 in order, all pos=1,
//     one every 2 cycles; ovf=0.
//   4 After ch2 accepted, ch1 and ch3 pending -> ch3 granted before ch1.
//   5 evt_ready=0; a[1] rises then falls -> offer (ch1,pos=1) held stable, ovf[1]=1.
//     Then evt_ready=1 -> single accept, no fall event. Then ovf_clr pulse -> ovf=0.
//   6 evt_valid=1 in OFFER; rst_n=0 for one cycle -> next cycle evt_valid=0, pend=0,
//     FSM=IDLE, no accept counted.

Source files
------------

// File: rtl/edge_event_arbiter_if.sv
// Event handshake bundle between edge_event_arbiter and its consumer.
//   evt_valid  master->slave  event offered on evt_ch/evt_pos
//   evt_ready  slave->master  consumer accepts when evt_valid=1
//   evt_ch     master->slave  channel index of the offered event
//   evt_pos    master->slave  1 = rising edge, 0 = falling edge
interface edge_event_arbiter_if #(
  parameter int CH_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_pos;

  modport master (output evt_valid, output evt_ch, output evt_pos, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, input evt_pos, output evt_ready);
endinterface

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler. Each level input is synchronized and
// edge-detected; every rising/falling edge becomes a pending event that is
// offered on a shared valid/ready port under round-robin arbitration.
//   clk        system clock, posedge
//   rst_n      synchronous reset, active low
//   a_i        raw level inputs, one per channel
//   evt        event handshake (master side)
//   pend_o     per-channel pending flags (includes the event being offered)
//   ovf_o      sticky per-channel overflow: edge dropped while already pending
//   ovf_clr_i  one-cycle pulse clearing all overflow bits
module edge_event_arbiter #(
  parameter int CH_NUM  = 4,
  parameter bit SYNC_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH_NUM-1:0]     a_i,
  edge_event_arbiter_if.master  evt,
  output logic [CH_NUM-1:0]     pend_o,
  output logic [CH_NUM-1:0]     ovf_o,
  input  logic                  ovf_clr_i
);
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic {IDLE, OFFER} state_t;

  logic [CH_NUM-1:0] sync_q, s_q, p_q, rise, fall, edge_any, clr;
  logic [CH_NUM-1:0] pend_vld_q, pend_vld_d, pend_pol_q, pend_pol_d;
  logic [CH_NUM-1:0] ovf_q, ovf_d;
  state_t            state_q, state_d;
  logic [CH_W-1:0]   evt_ch_q, evt_ch_d, last_grant_q, last_grant_d, pick;
  logic              evt_pos_q, evt_pos_d, found, accept;
  logic [CH_W:0]     idx_w;

  // Input capture: two metastability flops, or a single register for
  // inputs already synchronous to clk.
  if (SYNC_EN) begin : g_sync
    logic [CH_NUM-1:0] meta_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        meta_q <= '0;
        sync_q <= '0;
      end else begin
        meta_q <= a_i;
        sync_q <= meta_q;
      end
    end
  end else begin : g_nosync
    always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= a_i;
    end
  end

  // s_q is a registered copy of the captured level so the edge detector
  // only ever compares two plain registers; p_q is s_q one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q <= '0;
      p_q <= '0;
    end else begin
      s_q <= sync_q;
      p_q <= s_q;
    end
  end

  assign rise     = s_q & ~p_q;
  assign fall     = ~s_q & p_q;
  assign edge_any = rise | fall;
  assign accept   = (state_q == OFFER) & evt.evt_ready;

  // Pending bookkeeping. An accepted channel frees its slot in the same
  // cycle, so a coincident new edge is stored rather than counted as overflow.
  always_comb begin
    clr        = '0;
    pend_vld_d = pend_vld_q;
    pend_pol_d = pend_pol_q;
    ovf_d      = ovf_clr_i ? '0 : ovf_q;
    for (int i = 0; i < CH_NUM; i++) begin
      clr[i] = accept && (evt_ch_q == CH_W'(i));
      if (edge_any[i]) begin
        if (!pend_vld_q[i] || clr[i]) begin
          pend_vld_d[i] = 1'b1;
          pend_pol_d[i] = rise[i];
        end else begin
          ovf_d[i] = 1'b1;   // set wins over a same-cycle clear
        end
      end else if (clr[i]) begin
        pend_vld_d[i] = 1'b0;
      end
    end
  end

  // Round-robin pick: first pending channel after last_grant, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx_w = '0;
    for (int k = 1; k <= CH_NUM; k++) begin
      idx_w = {1'b0, last_grant_q} + (CH_W+1)'(k);
      if (idx_w >= (CH_W+1)'(CH_NUM)) idx_w = idx_w - (CH_W+1)'(CH_NUM);
      if (!found && pend_vld_q[idx_w[CH_W-1:0]]) begin
        found = 1'b1;
        pick  = idx_w[CH_W-1:0];
      end
    end
  end

  // FSM next state: the offer is frozen in OFFER until accepted.
  always_comb begin
    state_d      = state_q;
    evt_ch_d     = evt_ch_q;
    evt_pos_d    = evt_pos_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          evt_ch_d  = pick;
          evt_pos_d = pend_pol_q[pick];
          state_d   = OFFER;
        end
      end
      OFFER: begin
        if (evt.evt_ready) begin
          last_grant_d = evt_ch_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      evt_ch_q     <= '0;
      evt_pos_q    <= 1'b0;
      last_grant_q <= CH_W'(CH_NUM - 1);  // ch0 wins first
      pend_vld_q   <= '0;
      pend_pol_q   <= '0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      evt_ch_q     <= evt_ch_d;
      evt_pos_q    <= evt_pos_d;
      last_grant_q <= last_grant_d;
      pend_vld_q   <= pend_vld_d;
      pend_pol_q   <= pend_pol_d;
      ovf_q        <= ovf_d;
    end
  end

  assign evt.evt_valid = (state_q == OFFER);
  assign evt.evt_ch    = evt_ch_q;
  assign evt.evt_pos   = evt_pos_q;
  assign pend_o        = pend_vld_q;
  assign ovf_o         = ovf_q;
endmodule
